// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, return-stack depth and PC mux select encoding.
package cpu_pkg;
  localparam int PC_W = 12;
  localparam int RSTACK_DEPTH = 8;
  typedef enum logic [1:0] {
    PCSEL_NEXT   = 2'd0,
    PCSEL_JUMP   = 2'd1,
    PCSEL_RETURN = 2'd2,
    PCSEL_BRANCH = 2'd3
  } pc_sel_e;
endpackage

// File: rtl/return_stack_mem.sv
// return_stack_mem: DEPTH x AW register file, one write port, async read, async clear.
module return_stack_mem #(
  parameter int DEPTH = 8,
  parameter int AW = 12,
  localparam int SW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [SW-1:0] raddr,
  output logic [AW-1:0] rdata
);
  logic [AW-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/return_stack.sv
// return_stack: call/return address stack with sticky overflow/underflow flags.
// Define RETURN_STACK_WRAP_EN for circular mode (push on full overwrites the oldest entry).
module return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int AW = PC_W,
  localparam int SW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] pushAddr,
  input  logic          clrErr,
  output logic [AW-1:0] popAddr,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);
`ifdef RETURN_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [SW-1:0] sp, top, sp_nx;
  logic [CW-1:0] count_nx;
  logic [AW-1:0] rd;
  logic replace, grow, shrink, ovf_set, udf_set;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign top = sp - SW'(1);
  // push+pop on a non-empty stack rewrites the top in place; on empty it is a plain push
  assign replace = push & pop & ~empty;
  assign grow = push & ~replace & (~full | WRAP);
  assign shrink = pop & ~push & ~empty;
  assign ovf_set = push & ~pop & full & ~WRAP;
  assign udf_set = pop & empty;
  assign sp_nx = grow ? sp + SW'(1) : shrink ? top : sp;
  assign count_nx = (grow & ~full) ? count + CW'(1) : shrink ? count - CW'(1) : count;
  assign popAddr = empty ? '0 : rd;
  return_stack_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(replace | grow),
    .waddr(replace ? top : sp),
    .wdata(pushAddr),
    .raddr(top),
    .rdata(rd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp <= sp_nx;
      count <= count_nx;
      overflow <= ovf_set | (overflow & ~clrErr);
      underflow <= udf_set | (underflow & ~clrErr);
    end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed test-plan steps plus random traffic against a queue-based LIFO model.
module tb_return_stack;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, push = 0, pop = 0, clrErr = 0;
  logic [11:0] pushAddr = '0, popAddr;
  logic empty, full, overflow, underflow;
  logic [3:0] count;
  int n_cmp = 0, n_bad = 0;
  logic [11:0] q[$];
  bit m_ovf = 0, m_udf = 0;

  return_stack dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .pushAddr(pushAddr), .clrErr(clrErr),
    .popAddr(popAddr), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] m_top();
    return q.size() != 0 ? q[$] : 12'h000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".popAddr"}, 32'(popAddr), 32'(m_top()));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic model(input bit p, input bit o, input logic [11:0] a, input bit c);
    bit os = 0, us = 0;
    if (p && o) begin
      if (q.size() == 0) begin us = 1; q.push_back(a); end
      else q[q.size()-1] = a;
    end else if (p) begin
      if (q.size() < DEPTH) q.push_back(a);
      else begin
`ifdef RETURN_STACK_WRAP_EN
        void'(q.pop_front());
        q.push_back(a);
`else
        os = 1;
`endif
      end
    end else if (o) begin
      if (q.size() == 0) us = 1;
      else void'(q.pop_back());
    end
    m_ovf = os | (m_ovf & !c);
    m_udf = us | (m_udf & !c);
  endtask

  task automatic step(input bit p, input bit o, input logic [11:0] a, input bit c, input string tag);
    push = p; pop = o; pushAddr = a; clrErr = c;
    #1;
    chk({tag, ".pre"}, 32'(popAddr), 32'(m_top()));
    @(posedge clk);
    model(p, o, a, c);
    #1;
    push = 0; pop = 0; clrErr = 0;
    check_all(tag);
  endtask

  initial begin
    #2;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.empty", 32'(empty), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_all("reset");
    step(0, 1, 12'h000, 0, "pop_empty");
    chk("pop_empty.udf_const", 32'(underflow), 32'd1);
    step(0, 0, 12'h000, 1, "clr_err");
    chk("clr_err.udf_const", 32'(underflow), 32'd0);
    step(1, 0, 12'h010, 0, "lifo_push1");
    step(1, 0, 12'h020, 0, "lifo_push2");
    step(1, 0, 12'h030, 0, "lifo_push3");
    chk("lifo.top_const", 32'(popAddr), 32'h030);
    for (int i = 0; i < 3; i++) step(0, 1, 12'h000, 0, "lifo_pop");
    chk("lifo.empty_const", 32'(empty), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 12'(12'h101 + i), 0, "fill");
    step(1, 0, 12'hABC, 0, "push_full");
`ifdef RETURN_STACK_WRAP_EN
    chk("push_full.const_top", 32'(popAddr), 32'hABC);
    chk("push_full.const_ovf", 32'(overflow), 32'd0);
`else
    chk("push_full.const_top", 32'(popAddr), 32'h108);
    chk("push_full.const_ovf", 32'(overflow), 32'd1);
`endif
    step(1, 1, 12'h0DD, 0, "replace_full");
    for (int i = 0; i < DEPTH; i++) step(0, 1, 12'h000, 1, "drain");
    step(1, 0, 12'h010, 0, "pp_push1");
    step(1, 0, 12'h020, 0, "pp_push2");
    step(1, 1, 12'h055, 0, "pp_replace");
    chk("pp_replace.const", 32'(popAddr), 32'h055);
    step(0, 1, 12'h000, 0, "pp_pop1");
    step(0, 1, 12'h000, 0, "pp_pop2");
    step(1, 1, 12'h055, 0, "pp_empty");
    chk("pp_empty.const_count", 32'(count), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 12'(12'h200 + i), 0, "pre_rst");
    rst = 1;
    #1;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.empty", 32'(empty), 32'd1);
    chk("async_rst.popAddr", 32'(popAddr), 32'd0);
    q.delete(); m_ovf = 0; m_udf = 0;
    #1 rst = 0;
    check_all("async_rst");
    step(0, 1, 12'h000, 1, "clr_prio");
    chk("clr_prio.const", 32'(underflow), 32'd1);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      bit p = (i < 200) ? (r < 6) : (r < 3);
      bit o = (i < 200) ? (r >= 4 && r < 7) : (r >= 2 && r < 8);
      step(p, o, 12'($urandom), ($urandom_range(0, 7) == 0), "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack serving the controller's `push`/`pop` call/return interface. On a call it stores the return address supplied by the datapath. On a return it presents the most recent address combinationally, so the PC mux (`pcSel=2`) can use it in the same cycle. It sits beside the PC register in the fetch stage and reports overflow/underflow to the controller as sticky error flags.

## Interface
Parameters:
- `DEPTH`, 8 — number of entries; power of two, at least 2.
- `AW`, 12 — address width; matches `pc`.

Ports:
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — asynchronous, active-high reset.
- `push` input 1 — store `pushAddr` on this edge.
- `pop` input 1 — remove the top entry on this edge.
- `pushAddr` input AW — return address to store (pc+1 from the datapath).
- `clrErr` input 1 — synchronous clear of `overflow` and `underflow`.
- `popAddr` output AW — current top entry, combinational; 0 when empty.
- `empty` output 1 — count == 0.
- `full` output 1 — count == DEPTH.
- `count` output $clog2(DEPTH+1) — number of valid entries.
- `overflow` output 1 — sticky flag: a push was dropped.
- `underflow` output 1 — sticky flag: pop was issued while empty.

## Operation
- Storage is an array of DEPTH×AW entries. `sp` is a $clog2(DEPTH)-bit index of the next free slot, and the top entry is at `sp-1` (mod DEPTH).
- `popAddr` = mem[sp-1] when `count` ≠ 0, else 0. It is purely combinational from registered state.
- Actions per edge, decided by {push, pop}:
  - 00: hold.
  - 10, not full: mem[sp] ← pushAddr; sp+1; count+1.
  - 10, full: behaviour depends on the Configuration macro.
  - 01, not empty: sp−1; count−1. The entry contents are left as they were.
  - 01, empty: no state change; `underflow` ← 1.
  - 11, not empty: replace the top: mem[sp−1] ← pushAddr; sp and count unchanged. `overflow` is never set by this case, even when full.
  - 11, empty: `underflow` ← 1; then behaves as a plain push (count becomes 1).
- `clrErr` clears both flags. A flag event in the same cycle has priority: the flag ends the cycle set.
- Pointer arithmetic wraps modulo DEPTH. `count` saturates at DEPTH and at 0, and never wraps.

## Timing
- Reset (asynchronous): sp=0, count=0, empty=1, full=0, overflow=0, underflow=0, popAddr=0. All memory entries are cleared to 0.
- A push is visible on `popAddr` in the cycle after the edge (1-cycle latency).
- A pop: `popAddr` shows the old top during the pop cycle. The next entry is visible after the edge.
- Flags, `count`, `empty` and `full` are registered or decoded from registers, and update on the edge that causes them.
- Reset asserted mid-sequence discards all entries immediately. There is no pending-operation replay.
- No handshake: `push` and `pop` are single-cycle strobes. The controller holds them low while `hazard` is high.

## Configuration
- `RETURN_STACK_WRAP_EN` defined, circular mode:
  - Push on full overwrites the oldest entry: mem[sp] ← pushAddr, sp+1, count stays DEPTH.
  - `overflow` is never set.
- `RETURN_STACK_WRAP_EN` undefined:
  - Push on full is dropped; memory, sp and count are unchanged.
  - `overflow` ← 1.

## Structure
- Shared package `cpu_pkg` holds:
  - `PC_W` = 12, the default for AW.
  - `RSTACK_DEPTH` = 8.
  - The `pcSel` encoding constants (0 next, 1 jump, 2 return, 3 branch), shared with the controller.
- One sub-module is natural: `return_stack_mem`, a DEPTH×AW register file with one write port, one asynchronous read port and an asynchronous clear.
- Pointer, count and flag logic live in `return_stack`.

## Test plan
- **Reset, then pop:** pop with empty stack → popAddr=0, underflow=1 after the edge, count=0; then clrErr → underflow=0.
- **LIFO order:** push 0x010, 0x020, 0x030 on consecutive cycles → count=3, popAddr=0x030; three pops return 0x030, 0x020, 0x010; then empty=1.
- **Fill to DEPTH=8, then push 0xABC:**
  - Macro undefined → overflow=1, popAddr unchanged (eighth value), count=8.
  - Macro defined → popAddr=0xABC, overflow=0; eight pops return 0xABC followed by the 2nd–8th pushed values, newest first.
- **Simultaneous push+pop:**
  - At count=2 with top 0x020, pushAddr=0x055 → popAddr=0x020 during the cycle, 0x055 after it; count stays 2.
  - When empty → underflow=1, count=1, popAddr=0x055.
- **Async reset mid-operation:** rst pulsed between clock edges with count=5 → count=0, empty=1, popAddr=0 immediately, without waiting for a clock edge.
- **clrErr priority:** clrErr high in the same cycle as a pop on empty → underflow=1 after the edge.
